seven_seg_scan_ctrl: RTL

Scan scheduler for multiplexed seven-segment displays. It shares one segment bus between NUM_DIGITS digits and time-slices it. Each slot has dead-time blanking against ghosting and PWM brightness. New patterns enter a double buffer through a valid/ready handshake and reach the display only on frame boundaries. The block sits between the nibble decoders and the PMOD segment/digit-select pins.

---
 rtl/seven_seg_scan_ctrl_if.sv | 12 +
 rtl/seven_seg_scan_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Pattern-load channel for seven_seg_scan_ctrl: a valid/ready handshake that
// carries one 7-bit segment pattern per digit.
interface seven_seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 2
);
  logic [NUM_DIGITS*7-1:0] digit_in;
  logic                    load_valid;
  logic                    load_ready;

  modport master (output digit_in, output load_valid, input load_ready);
  modport slave  (input digit_in, input load_valid, output load_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan scheduler: blanking, PWM brightness and a
// frame-synchronous double buffer. Optional lamp test: define SEG_SCAN_LAMP_TEST_EN.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned CLK_DIV      = 16000,
  parameter int unsigned BLANK_CYCLES = 160,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seven_seg_scan_ctrl_if.slave          load,
  input  logic [BRIGHT_W-1:0]           brightness,
`ifdef SEG_SCAN_LAMP_TEST_EN
  input  logic                          lamp_test,
`endif
  output logic [6:0]                    segout,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W  = $clog2(CLK_DIV);
  localparam int unsigned PROD_W = $clog2(CLK_DIV + 1) + BRIGHT_W + 1;
  localparam int unsigned SPAN   = CLK_DIV - BLANK_CYCLES;

  typedef enum logic [1:0] {BLANK, ON, DARK} state_t;

  state_t                       state, state_next;
  logic [CNT_W-1:0]             cnt, cnt_next;
  logic [IDX_W-1:0]             idx_next;
  logic [BRIGHT_W-1:0]          bright_q, bright_slot;
  logic [NUM_DIGITS-1:0][6:0]   active, shadow, active_next, shadow_next;
  logic                         ready_q, ready_next;
  logic [6:0]                   segout_next;
  logic [NUM_DIGITS-1:0]        digit_en_next;
  logic                         frame_tick_next;
  logic [PROD_W-1:0]            on_cycles, on_end;
  logic                         wrap, accept, transfer, lamp;

`ifdef SEG_SCAN_LAMP_TEST_EN
  assign lamp = lamp_test;
`else
  assign lamp = 1'b0;
`endif

  assign load.load_ready = ready_q;

  // All registers, including the outputs, which are loaded with next-cycle values
  // so that segout/digit_en/frame_tick line up with the slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      bright_q   <= '0;
      active     <= '0;
      shadow     <= '0;
      ready_q    <= 1'b1;
      segout     <= '0;
      digit_en   <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      digit_idx  <= idx_next;
      bright_q   <= bright_slot;
      active     <= active_next;
      shadow     <= shadow_next;
      ready_q    <= ready_next;
      segout     <= segout_next;
      digit_en   <= digit_en_next;
      frame_tick <= frame_tick_next;
    end
  end

  always_comb begin
    wrap            = (cnt == CNT_W'(CLK_DIV - 1));
    cnt_next        = wrap ? '0 : cnt + CNT_W'(1);
    idx_next        = digit_idx;
    state_next      = state;
    segout_next     = '0;
    digit_en_next   = '0;
    ready_next      = ready_q;

    if (wrap) begin
      idx_next = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end

    // Brightness is captured in the counter==0 cycle and held for the slot.
    bright_slot = (cnt == '0) ? brightness : bright_q;
    on_cycles   = PROD_W'((PROD_W'(SPAN) * (PROD_W'(bright_slot) + PROD_W'(1))) >> BRIGHT_W);
    on_end      = PROD_W'(BLANK_CYCLES) + on_cycles;

    unique case (state)
      BLANK: if (cnt_next == CNT_W'(BLANK_CYCLES)) state_next = (on_cycles == '0) ? DARK : ON;
      ON:    if (PROD_W'(cnt_next) == on_end) state_next = DARK;
      DARK:  state_next = DARK;
      default: state_next = BLANK;
    endcase
    if (wrap) state_next = BLANK;

    // Shadow->active only at the frame boundary; a same-cycle accept lands in shadow.
    accept      = load.load_valid && ready_q;
    transfer    = frame_tick && !ready_q;
    active_next = transfer ? shadow : active;
    shadow_next = accept ? load.digit_in : shadow;
    if (transfer) ready_next = 1'b1;
    if (accept)   ready_next = 1'b0;

    frame_tick_next = (cnt_next == CNT_W'(CLK_DIV - 1)) && (idx_next == IDX_W'(NUM_DIGITS - 1));
    if (state_next == ON) begin
      segout_next   = lamp ? 7'h7F : active[idx_next];
      digit_en_next = NUM_DIGITS'(1) << idx_next;
    end
  end
endmodule
